// File: rtl/beamform_pkg.sv
// Shared constants, types and the default beam delay table for the beamform trigger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sample/channel/threshold widths, frame and history types, delay table,
//           sample sign-extension helper.
package beamform_pkg;

  localparam int SAMPLE_W     = 5;   // signed sample width
  localparam int NCHAN        = 8;   // input channels
  localparam int NSAMP        = 8;   // samples per channel per clock
  localparam int THRESH_W     = 18;  // threshold / window power width
  localparam int DELAY_W      = 4;   // per-channel delay, 0..15 samples
  localparam int MAX_BEAMS    = 256;

  localparam int WORD_W       = SAMPLE_W * NSAMP;   // one channel word, 40 bits
  localparam int HIST_WORDS   = 3;                  // current word + 2 previous
  localparam int HIST_SAMPLES = HIST_WORDS * NSAMP; // 24 samples per channel
  localparam int HIST_W       = HIST_SAMPLES * SAMPLE_W;

  localparam int BEAM_W       = 8;         // signed beam sample, -128..120
  localparam int SQ_W         = 15;        // squared beam sample, max 16384
  localparam int POWER_W      = THRESH_W;  // window power, max 131072

  typedef logic [NCHAN-1:0][WORD_W-1:0]              frame_t;
  typedef logic [NCHAN-1:0][HIST_W-1:0]              hist_t;
  typedef logic [NCHAN-1:0][DELAY_W-1:0]             chan_delays_t;
  typedef logic [MAX_BEAMS-1:0][NCHAN-1:0][DELAY_W-1:0] delay_table_t;

  // Beam b steers channel ch by (b*ch) mod 16 samples; beam 0 is broadside (all zero).
  function automatic delay_table_t default_delays();
    delay_table_t d;
    d = '0;
    for (int b = 0; b < MAX_BEAMS; b++) begin
      for (int ch = 0; ch < NCHAN; ch++) begin
        d[b][ch] = DELAY_W'((b * ch) % (1 << DELAY_W));
      end
    end
    return d;
  endfunction

  localparam delay_table_t DEFAULT_BEAM_DELAYS = default_delays();

  function automatic logic [BEAM_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(BEAM_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/beamform_trigger_core_if.sv
// Bundles the sample bus, threshold staging controls and trigger output of the core.
// Latency: n/a (wires only).
// Backpressure: none; the stream is consumed every clock.
// Ports: data_i (8ch x 8 samples), thresh_i, thresh_ce_i[NBEAMS], update_i, trigger_o[NBEAMS].
interface beamform_trigger_core_if
  import beamform_pkg::*;
#(
  parameter int NBEAMS = 2
);

  frame_t                data_i;
  logic [THRESH_W-1:0]   thresh_i;
  logic [NBEAMS-1:0]     thresh_ce_i;
  logic                  update_i;
  logic [NBEAMS-1:0]     trigger_o;

  modport master (
    output data_i, thresh_i, thresh_ce_i, update_i,
    input  trigger_o
  );

  modport slave (
    input  data_i, thresh_i, thresh_ce_i, update_i,
    output trigger_o
  );

endinterface

// File: rtl/beamform_trigger_core_beam_power.sv
// One beam: delay-select and sum across channels, square, then sum 8 squares into window power.
// Latency: 3 clocks from history window to power_o.
// Backpressure: none; a new window is accepted every clock.
// Ports: clk_i, rst_i (sync, active-high), hist_i (24 samples per channel), power_o (18b).
module beam_power
  import beamform_pkg::*;
#(
  parameter chan_delays_t DELAYS = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  hist_t              hist_i,
  output logic [POWER_W-1:0] power_o
);

  logic [NSAMP-1:0][BEAM_W-1:0] beam_d, beam_q;
  logic [NSAMP-1:0][SQ_W-1:0]   sq_d, sq_q;
  logic [POWER_W-1:0]           power_d, power_q;
  logic [BEAM_W-1:0]            mag;

  // Slot k of the current word lives at history position 16+k; a delay of d
  // reaches back d samples, at most into the oldest word (position >= 1).
  always_comb begin
    beam_d = '0;
    for (int k = 0; k < NSAMP; k++) begin
      for (int ch = 0; ch < NCHAN; ch++) begin
        beam_d[k] = beam_d[k] + sext_sample(
          hist_i[ch][(2 * NSAMP + k - int'(DELAYS[ch])) * SAMPLE_W +: SAMPLE_W]);
      end
    end
  end

  // |x| fits 8 unsigned bits even for -128, so the square fits 15 bits.
  always_comb begin
    sq_d = '0;
    mag  = '0;
    for (int k = 0; k < NSAMP; k++) begin
      mag     = beam_q[k][BEAM_W-1] ? (~beam_q[k] + 1'b1) : beam_q[k];
      sq_d[k] = SQ_W'(mag) * SQ_W'(mag);
    end
  end

  always_comb begin
    power_d = '0;
    for (int k = 0; k < NSAMP; k++) begin
      power_d = power_d + POWER_W'(sq_q[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beam_q  <= '0;
      sq_q    <= '0;
      power_q <= '0;
    end else begin
      beam_q  <= beam_d;
      sq_q    <= sq_d;
      power_q <= power_d;
    end
  end

  assign power_o = power_q;

endmodule

// File: rtl/beamform_trigger_core.sv
// Per-beam power trigger: sample history, per-beam power pipelines, double-buffered thresholds, compare.
// Latency: trigger_o reflects the data_i word presented 4 clocks earlier.
// Backpressure: none; data_i is consumed every clock, trigger_o is a level.
// Ports: clk_i, rst_i (sync, active-high), bus (slave: data_i, thresh_i, thresh_ce_i, update_i, trigger_o).
module beamform_trigger_core
  import beamform_pkg::*;
#(
  parameter int NBEAMS = 2,
  parameter logic [NBEAMS-1:0][NCHAN-1:0][DELAY_W-1:0] BEAM_DELAYS =
    DEFAULT_BEAM_DELAYS[NBEAMS-1:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  beamform_trigger_core_if.slave bus
);

  frame_t hist1_q, hist2_q;   // previous word and the one before it
  hist_t  hist_win;

  logic [POWER_W-1:0]                power [NBEAMS];
  logic [NBEAMS-1:0][THRESH_W-1:0]   staging_q, active_q;
  logic [NBEAMS-1:0]                 trigger_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      hist1_q <= bus.data_i;
      hist2_q <= hist1_q;
    end
  end

  // Oldest word in the low bits so a sample's history position grows with time.
  always_comb begin
    hist_win = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      hist_win[ch] = {bus.data_i[ch], hist1_q[ch], hist2_q[ch]};
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    beam_power #(
      .DELAYS (BEAM_DELAYS[b])
    ) u_beam_power (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hist_i  (hist_win),
      .power_o (power[b])
    );
  end

  // Reset thresholds sit above the largest reachable power, so nothing fires
  // until software stages and commits real values. The commit reads the staging
  // value from before this clock, so a coincident stage waits for the next update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      staging_q <= '1;
      active_q  <= '1;
    end else begin
      if (bus.update_i) begin
        active_q <= staging_q;
      end
      for (int b = 0; b < NBEAMS; b++) begin
        if (bus.thresh_ce_i[b]) begin
          staging_q[b] <= bus.thresh_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_q <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        trigger_q[b] <= (power[b] > active_q[b]);
      end
    end
  end

  assign bus.trigger_o = trigger_q;

endmodule

// File: tb/tb_beamform_trigger_core.sv
// Randomised and directed stimulus against a sample-stream reference model with a scoreboard.
// Latency: expected trigger for each clock is queued at the edge, checked at the following negedge.
// Backpressure: none.
module tb_beamform_trigger_core;
  import beamform_pkg::*;

  localparam int NB   = 2;
  localparam int NE   = 2000;
  localparam int TMAX = (1 << THRESH_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beamform_trigger_core_if #(.NBEAMS(NB)) bus ();

  beamform_trigger_core #(.NBEAMS(NB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int            edge_n;
    logic [NB-1:0] trig;
  } exp_t;

  frame_t words [NE];
  bit     rst_at [NE];
  int     stg [NB];
  int     act [NB];
  int     act_before [NB];
  int     edge_cnt = 0;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int samp(input frame_t f, input int ch, input int k);
    logic signed [SAMPLE_W-1:0] s;
    s = f[ch][SAMPLE_W * k +: SAMPLE_W];
    return int'(s);
  endfunction

  function automatic int power_ref(input int w, input int b);
    int total, bs, n;
    total = 0;
    for (int k = 0; k < NSAMP; k++) begin
      bs = 0;
      for (int ch = 0; ch < NCHAN; ch++) begin
        n = NSAMP * w + k - int'(DEFAULT_BEAM_DELAYS[b][ch]);
        if (n >= 0) bs += samp(words[n / NSAMP], ch, n % NSAMP);
      end
      total += bs * bs;
    end
    return total;
  endfunction

  function automatic frame_t const_frame(input int v);
    frame_t f;
    for (int ch = 0; ch < NCHAN; ch++)
      for (int k = 0; k < NSAMP; k++)
        f[ch][SAMPLE_W * k +: SAMPLE_W] = SAMPLE_W'(v);
    return f;
  endfunction

  function automatic frame_t rand_frame(input int amp);
    frame_t f;
    int v;
    for (int ch = 0; ch < NCHAN; ch++)
      for (int k = 0; k < NSAMP; k++) begin
        v = int'($urandom_range(0, 2 * amp)) - amp;
        f[ch][SAMPLE_W * k +: SAMPLE_W] = SAMPLE_W'(v);
      end
    return f;
  endfunction

  task automatic step(input bit r, input frame_t d, input int th,
                      input logic [NB-1:0] ce, input bit up);
    int e;
    bit recent_rst;
    exp_t x;
    rst             = r;
    bus.data_i      = d;
    bus.thresh_i    = THRESH_W'(th);
    bus.thresh_ce_i = ce;
    bus.update_i    = up;
    @(posedge clk);
    e = edge_cnt;
    rst_at[e] = r;
    words[e]  = d;
    for (int b = 0; b < NB; b++) act_before[b] = act[b];
    if (r) begin
      for (int i = 0; i < HIST_WORDS; i++)
        if (e - i >= 0) words[e - i] = '0;
      for (int b = 0; b < NB; b++) begin
        stg[b] = TMAX;
        act[b] = TMAX;
      end
    end else begin
      if (up) for (int b = 0; b < NB; b++) act[b] = stg[b];
      for (int b = 0; b < NB; b++) if (ce[b]) stg[b] = th;
    end
    recent_rst = (e < 3);
    for (int i = 0; i <= 3; i++)
      if (e - i >= 0 && rst_at[e - i]) recent_rst = 1'b1;
    x.edge_n = e;
    for (int b = 0; b < NB; b++)
      x.trig[b] = recent_rst ? 1'b0 : (power_ref(e - 3, b) > act_before[b]);
    sb_q.push_back(x);
    edge_cnt++;
    #1;
  endtask

  task automatic run(input int n, input int v);
    for (int i = 0; i < n; i++) step(1'b0, const_frame(v), 0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      n_checks++;
      if (bus.trigger_o === mon_x.trig) n_pass++;
      else $display("FAIL trigger edge %0d: got %b expected %b",
                    mon_x.edge_n, bus.trigger_o, mon_x.trig);
    end
  end

  initial begin
    int amp;
    int waited;
    bit seen;
    logic [NB-1:0] ce;
    for (int b = 0; b < NB; b++) begin
      stg[b] = TMAX;
      act[b] = TMAX;
    end
    rst = 1'b1;
    bus.data_i = '0;
    bus.thresh_i = '0;
    bus.thresh_ce_i = '0;
    bus.update_i = 1'b0;

    // Reset state, then full-scale +15 with reset thresholds: never fires.
    for (int i = 0; i < 5; i++) step(1'b1, rand_frame(15), 0, '0, 1'b0);
    run(10, 15);
    n_checks++;
    if (bus.trigger_o === '0) n_pass++;
    else $display("FAIL reset state: trigger_o %b expected 0 with reset thresholds",
                  bus.trigger_o);

    // Threshold 1000 on beam 0, steady 2 (power 2048) fires; steady 1 (512) does not.
    step(1'b0, const_frame(2), 1000, 2'b01, 1'b0);
    step(1'b0, const_frame(2), 0, '0, 1'b1);
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, const_frame(2), 0, '0, 1'b0);
      if (!seen) begin
        waited++;
        if (bus.trigger_o[0] === 1'b1) seen = 1'b1;
      end
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL timeout: trigger_o[0] not asserted within %0d clocks", waited);
    run(8, 1);

    // Strict compare: 2048 does not fire at power 2048, 2047 does.
    step(1'b0, const_frame(2), 2048, 2'b01, 1'b0);
    step(1'b0, const_frame(2), 0, '0, 1'b1);
    run(8, 2);
    step(1'b0, const_frame(2), 2047, 2'b01, 1'b0);
    step(1'b0, const_frame(2), 0, '0, 1'b1);
    run(8, 2);

    // Stage 0 on beam 1 without commit, then commit alone.
    step(1'b0, const_frame(2), 0, 2'b10, 1'b0);
    run(8, 2);
    step(1'b0, const_frame(2), 0, '0, 1'b1);
    run(8, 2);

    // Stage 5000, then commit coincident with staging 0: 5000 applies, 0 waits.
    step(1'b0, const_frame(2), 5000, 2'b01, 1'b0);
    step(1'b0, const_frame(2), 0, 2'b01, 1'b1);
    run(8, 2);
    step(1'b0, const_frame(2), 0, '0, 1'b1);
    run(6, 2);

    // Reset while triggering, then maximum-power data with a commit of reset staging.
    step(1'b1, const_frame(2), 0, 2'b11, 1'b1);
    run(5, -16);
    step(1'b0, const_frame(-16), 0, '0, 1'b1);
    run(8, -16);

    // Random traffic: amplitude changes every 16 clocks, random staging/commits/resets.
    amp = 7;
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        case ($urandom_range(0, 4))
          0: amp = 0;
          1: amp = 1;
          2: amp = 3;
          3: amp = 7;
          default: amp = 15;
        endcase
      end
      ce = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(1, 3)) : '0;
      step(($urandom_range(0, 199) == 0), rand_frame(amp),
           int'($urandom_range(0, 12000)), ce, ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
